mem_access_ctrl: RTL and testbench

Sequencer for the data-memory access of the RV32I pipeline's MEM stage. It observes the EX/MEM pipeline-register outputs (MemRead, MemWrite, ALU result as address, Data_out2 as store data, funct3). It drives a request/acknowledge handshake to a variable-latency data memory and formats load data and store byte enables. It stalls the whole pipeline until the access completes, times out, or is rejected as misaligned.

---
 rtl/rv32_pkg.sv | 28 ++
 rtl/load_align.sv | 28 ++
 rtl/mem_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the MEM-stage data-memory access path:
// funct3 load/store codes, the access-sequencer state encoding and an alignment helper.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // Access size comes from funct3[1:0]: 00 byte, 01 halfword, anything else a word.
    function automatic logic is_misaligned(input logic [1:0] size_code, input logic [1:0] byte_off);
        logic mis;
        case (size_code)
            2'b00:   mis = 1'b0;
            2'b01:   mis = byte_off[0];
            default: mis = (byte_off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it; no state, no latency, no backpressure.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] ldata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*byte_off +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
        ldata    = rdata;
        case (funct3)
            F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ldata = {24'h0, byte_sel};
            F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ldata = {16'h0, half_sel};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: req/ack handshake to variable-latency data memory, >=1 cycle per access.
// Holds pipe_stall high until the access acks, times out, or is rejected as misaligned.
module mem_access_ctrl
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        pipe_stall,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] load_q, load_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        mem_op;
    logic        is_store;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_load;

    // A simultaneous read+write is treated as a store.
    assign mem_op   = mem_read | mem_write;
    assign is_store = mem_write;

    load_align u_load_align (
        .rdata    (dmem_rdata),
        .byte_off (addr[1:0]),
        .funct3   (funct3),
        .ldata    (fmt_load)
    );

    always_comb begin
        fmt_wdata = store_data;
        fmt_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                fmt_wdata = {4{store_data[7:0]}};
                fmt_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{store_data[15:0]}};
                fmt_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt_wdata = store_data;
                fmt_be    = 4'b1111;
            end
        endcase
        if (!is_store) begin
            fmt_be = 4'b1111;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        load_d  = load_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (is_misaligned(funct3[1:0], addr[1:0])) begin
                        state_d = ST_DONE;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {addr[31:2], 2'b00};
                        wdata_d = fmt_wdata;
                        be_d    = fmt_be;
                        cnt_d   = 8'd0;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!is_store) begin
                        load_d = fmt_load;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Abandon the access; a timed-out load returns zero.
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    if (!is_store) begin
                        load_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            load_q  <= 32'h0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            load_q  <= load_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // DONE releases the pipeline so the next negedge can advance EX/MEM.
    assign pipe_stall   = mem_op & (state_q != ST_DONE);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign load_data    = load_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl (TIMEOUT_CYCLES=4): directed plan cases, reset abort,
// then random loads/stores scored against an arithmetic reference model.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, store_data;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        pipe_stall;
    logic [31:0] load_data;
    logic        misalign_err, bus_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ld = 32'h0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr         (addr),
        .store_data   (store_data),
        .funct3       (funct3),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .pipe_stall   (pipe_stall),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        int s;
        case (f3 % 4)
            0:       s = 1;
            1:       s = 2;
            default: s = 4;
        endcase
        return s;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % access_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int s;
        int off;
        s   = access_size(f3);
        off = int'(a % 4);
        if (!st || s == 4) return 4'b1111;
        if (s == 1) return 4'(1 << off);
        return (off >= 2) ? 4'b1100 : 4'b0011;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int s;
        s = access_size(f3);
        if (s == 1) return (d & 32'hFF) * 32'h01010101;
        if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int          off;
        off = int'(a % 4);
        v   = w;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (w >> (8 * (off / 2) * 2)) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    // One memory instruction from EX/MEM entry to the cycle after DONE.
    // ack_at = ACCESS cycle on which memory acks (0 or >TO: never).
    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] sd, input logic [2:0] f3, input int ack_at,
                         input logic [31:0] rdata);
        logic        mis, st, tmo, done, stable;
        int          exp_req, exp_stall, nreq, nstall;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;
        logic        we0;
        st  = wr;
        mis = model_mis(f3, a);
        tmo = !mis && !(ack_at >= 1 && ack_at <= TO);
        if (mis) begin
            exp_req = 0; exp_stall = 1;
        end else if (tmo) begin
            exp_req = TO; exp_stall = TO + 1;
        end else begin
            exp_req = ack_at; exp_stall = ack_at + 1;
        end
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; store_data = sd; funct3 = f3;
        dmem_ack = 1'b0; dmem_rdata = rdata;
        #1;
        nreq = 0; nstall = 0; done = 1'b0; stable = 1'b1;
        a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            if (n > 0) begin
                @(negedge clk);
                #1;
            end
            if (dmem_req) begin
                nreq++;
                if (nreq == 1) begin
                    a0 = dmem_addr; wd0 = dmem_wdata; be0 = dmem_be; we0 = dmem_we;
                    check(tag, "we", {31'h0, dmem_we}, {31'h0, st});
                    check(tag, "addr", dmem_addr, a & 32'hFFFFFFFC);
                    check(tag, "be", {28'h0, dmem_be}, {28'h0, model_be(st, f3, a)});
                    if (st) check(tag, "wdata", dmem_wdata, model_wdata(f3, sd));
                end else if (dmem_addr !== a0 || dmem_wdata !== wd0 || dmem_be !== be0 || dmem_we !== we0) begin
                    stable = 1'b0;
                end
            end
            if (pipe_stall) nstall++;
            else done = 1'b1;
            if (!done) dmem_ack = dmem_req && (nreq == ack_at);
        end
        check(tag, "completed", {31'h0, done}, 32'h1);
        check(tag, "req_cycles", nreq, exp_req);
        check(tag, "stall_negedges", nstall, exp_stall);
        if (nreq > 1) check(tag, "req_stable", {31'h0, stable}, 32'h1);
        check(tag, "req_dropped", {31'h0, dmem_req}, 32'h0);
        check(tag, "misalign_err", {31'h0, misalign_err}, {31'h0, mis});
        check(tag, "bus_err", {31'h0, bus_err}, {31'h0, tmo});
        if (!st && !mis) exp_ld = tmo ? 32'h0 : model_load(rdata, a, f3);
        check(tag, "load_data", load_data, exp_ld);
        mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        #1;
        check(tag, "pulse_clear", {30'h0, misalign_err, bus_err}, 32'h0);
        check(tag, "load_held", load_data, exp_ld);
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0; store_data = 32'h0;
        funct3 = 3'd2; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #2;
        check("reset", "pipe_stall", {31'h0, pipe_stall}, 32'h1);
        check("reset", "req_we_err", {28'h0, dmem_req, dmem_we, misalign_err, bus_err}, 32'h0);
        check("reset", "addr", dmem_addr, 32'h0);
        check("reset", "wdata", dmem_wdata, 32'h0);
        check("reset", "be", {28'h0, dmem_be}, 32'h0);
        check("reset", "load_data", load_data, 32'h0);
        mem_read = 1'b0;
        #1;
        check("reset", "stall_no_op", {31'h0, pipe_stall}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_op("lw_ack3",  1'b1, 1'b0, 32'h100, 32'h0,      3'd2, 3, 32'hDEADBEEF);
        do_op("lb_103",   1'b1, 1'b0, 32'h103, 32'h0,      3'd0, 1, 32'h80112233);
        do_op("lbu_103",  1'b1, 1'b0, 32'h103, 32'h0,      3'd4, 2, 32'h80112233);
        do_op("sh_202",   1'b0, 1'b1, 32'h202, 32'hABCD,   3'd1, 1, 32'h0);
        do_op("lw_mis",   1'b1, 1'b0, 32'h101, 32'h0,      3'd2, 1, 32'h12345678);
        do_op("lw_tmo",   1'b1, 1'b0, 32'h104, 32'h0,      3'd2, 0, 32'h55555555);
        do_op("lh_ok",    1'b1, 1'b0, 32'h106, 32'h0,      3'd1, 4, 32'h8001_7FFF);
        do_op("sb_tmo",   1'b0, 1'b1, 32'h10A, 32'h1234_56A5, 3'd0, 0, 32'h0);

        // Ack while idle must have no effect.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        check("idle_ack", "req", {31'h0, dmem_req}, 32'h0);
        check("idle_ack", "load_data", load_data, exp_ld);
        dmem_ack = 1'b0;

        // Reset during the second ACCESS cycle.
        @(negedge clk);
        mem_read = 1'b1; addr = 32'h400; funct3 = 3'd2;
        @(negedge clk);
        #1;
        check("rst_mid", "req_c1", {31'h0, dmem_req}, 32'h1);
        @(negedge clk);
        #1;
        check("rst_mid", "req_c2", {31'h0, dmem_req}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid", "req_async_drop", {31'h0, dmem_req}, 32'h0);
        check("rst_mid", "load_data", load_data, 32'h0);
        exp_ld = 32'h0;
        @(negedge clk);
        reset = 1'b0; mem_read = 1'b0;
        do_op("sw_after", 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 3'd2, 2, 32'h0);
        do_op("lw_after", 1'b1, 1'b0, 32'h300, 32'h0,        3'd2, 1, 32'hCAFEF00D);

        for (int i = 0; i < 30; i++) begin
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a  = $urandom;
            do_op("random", rd, wr, a, $urandom, f3, int'($urandom_range(0, 5)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
